// File: rtl/aho_monitor.sv
// Receive-side checker for the single-bit AHO pattern stream: recovers frame
// alignment from the three-zero run, then checks every bit against a local model.
module aho_monitor #(
  parameter int ERR_W      = 16,
  parameter int MISS_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             AHO_IN,
  output logic             LOCK,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       PHASE,
  output logic             FRAME
);

  // state  | meaning
  // HUNT   | searching for the exact third zero of a run (sample k=2)
  // LOCKED | model aligned, every sample compared against exp(cnt)
  typedef enum logic {HUNT, LOCKED} state_t;

  // bit p holds the pattern bit for phase p; bit 0 is unused (k=0 is always 0)
  localparam logic [15:0] PAT = 16'hD6E8;

  state_t      state;
  logic [1:0]  zrun;
  logic [15:0] cnt;
  logic [3:0]  ph;
  logic [3:0]  miss;

  logic        exp_bit;
  logic        mismatch;
  logic [3:0]  miss_next;
  logic        lose;

  always_comb begin
    exp_bit   = (cnt == 16'd0) ? 1'b0 : PAT[ph];
    mismatch  = AHO_IN ^ exp_bit;
    miss_next = ((ph == 4'd1) ? 4'd0 : miss) + {3'b000, mismatch};
    lose      = (miss_next == 4'(MISS_LIMIT));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= HUNT;
      zrun    <= 2'd0;
      cnt     <= 16'd0;
      ph      <= 4'd0;
      miss    <= 4'd0;
      LOCK    <= 1'b0;
      ERR     <= 1'b0;
      FRAME   <= 1'b0;
      PHASE   <= 4'd0;
      ERR_CNT <= '0;
    end else begin
      if (AHO_IN)
        zrun <= 2'd0;
      else if (zrun != 2'd3)
        zrun <= zrun + 2'd1;

      case (state)
        HUNT: begin
          ERR   <= 1'b0;
          FRAME <= 1'b0;
          PHASE <= 4'd0;
          if (!AHO_IN && zrun == 2'd2) begin
            state <= LOCKED;
            cnt   <= 16'd3;
            ph    <= 4'd3;
            miss  <= 4'd0;
            LOCK  <= 1'b1;
          end else begin
            LOCK  <= 1'b0;
          end
        end
        LOCKED: begin
          ERR   <= mismatch;
          FRAME <= (cnt == 16'd0);
          PHASE <= ph;
          cnt   <= cnt + 16'd1;
          if (cnt == 16'hFFFF)
            ph <= 4'd0;
          else if (ph == 4'd15 || ph == 4'd0)
            ph <= 4'd1;
          else
            ph <= ph + 4'd1;
          if (lose) begin
            state <= HUNT;
            miss  <= 4'd0;
            LOCK  <= 1'b0;
          end else begin
            miss  <= miss_next;
            LOCK  <= 1'b1;
          end
          // the losing mismatch is still counted
          if (mismatch && ERR_CNT != '1)
            ERR_CNT <= ERR_CNT + 1'b1;
        end
        default: begin
          state <= HUNT;
          LOCK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aho_monitor.sv
// Scoreboard bench for aho_monitor: a behavioural frame-index model predicts every
// registered output; a narrow-counter instance exercises ERR_CNT saturation.
module tb_aho_monitor;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AHO_IN = 1'b0;
  logic        lock, err, frame;
  logic [15:0] err_cnt;
  logic [3:0]  phase;
  logic        lock_s, err_s, frame_s;
  logic [2:0]  err_cnt_s;
  logic [3:0]  phase_s;

  aho_monitor #(.ERR_W(16), .MISS_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST), .AHO_IN(AHO_IN), .LOCK(lock), .ERR(err),
    .ERR_CNT(err_cnt), .PHASE(phase), .FRAME(frame)
  );

  aho_monitor #(.ERR_W(3), .MISS_LIMIT(4)) dut_s (
    .CLK(CLK), .RST(RST), .AHO_IN(AHO_IN), .LOCK(lock_s), .ERR(err_s),
    .ERR_CNT(err_cnt_s), .PHASE(phase_s), .FRAME(frame_s)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       lock;
    logic       err;
    logic       frame;
    logic [3:0] phase;
    int         c16;
    int         c3;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int pat_tab[15] = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 0, 1, 1};

  // model state
  bit m_lock;
  int m_zrun, m_k, m_miss, m_c16, m_c3;
  // generator state
  int gen_k;
  int flips[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phase_of(input int k);
    return (k == 0) ? 0 : ((k - 1) % 15) + 1;
  endfunction

  function automatic logic gen_bit(input int k);
    return (k == 0) ? 1'b0 : pat_tab[phase_of(k) - 1][0];
  endfunction

  task automatic model_reset();
    m_lock = 0; m_zrun = 0; m_k = 0; m_miss = 0; m_c16 = 0; m_c3 = 0;
  endtask

  task automatic model_step(input logic b, output exp_t e);
    int  ph, mn;
    logic expb, mm;
    e.err = 0; e.frame = 0; e.phase = 0;
    if (!m_lock) begin
      if (b == 1'b0 && m_zrun == 2) begin
        m_lock = 1; m_k = 3; m_miss = 0;
      end
    end else begin
      ph   = phase_of(m_k);
      expb = (m_k == 0) ? 1'b0 : pat_tab[ph - 1][0];
      mm   = (b != expb);
      mn   = ((ph == 1) ? 0 : m_miss) + int'(mm);
      e.err   = mm;
      e.frame = (m_k == 0);
      e.phase = 4'(ph);
      if (mm) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c3 < 7) m_c3++;
      end
      if (mn == 4) begin
        m_lock = 0; m_miss = 0;
      end else begin
        m_miss = mn;
      end
      m_k = (m_k + 1) % 65536;
    end
    m_zrun = b ? 0 : ((m_zrun == 3) ? 3 : m_zrun + 1);
    e.lock = m_lock;
    e.c16  = m_c16;
    e.c3   = m_c3;
  endtask

  task automatic step(input logic b);
    exp_t e;
    @(negedge CLK);
    AHO_IN = b;
    model_step(b, e);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("lock",    32'(lock),      32'(e.lock));
    check("err",     32'(err),       32'(e.err));
    check("frame",   32'(frame),     32'(e.frame));
    check("phase",   32'(phase),     32'(e.phase));
    check("err_cnt", 32'(err_cnt),   32'(e.c16));
    check("err_sat", 32'(err_cnt_s), 32'(e.c3));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lock"},  32'(lock),    0);
    check({tag, "_err"},   32'(err),     0);
    check({tag, "_frame"}, 32'(frame),   0);
    check({tag, "_phase"}, 32'(phase),   0);
    check({tag, "_cnt"},   32'(err_cnt), 0);
    check({tag, "_sat"},   32'(err_cnt_s), 0);
  endtask

  // RST is asserted mid-cycle and released mid-high so no edge samples unmodelled data
  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b0;
    model_reset();
    #1 check_zero("rst_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      AHO_IN = ~AHO_IN;
    end
    #1 check_zero("rst_held");
    @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  task automatic run(input int n, input int every);
    logic b;
    bit   f;
    for (int i = 0; i < n; i++) begin
      b = gen_bit(gen_k);
      f = (every > 0 && gen_k >= 5 && gen_k % every == 0);
      foreach (flips[j]) if (flips[j] == gen_k) f = 1;
      step(b ^ f);
      gen_k = (gen_k + 1) % 65536;
    end
  endtask

  task automatic restart();
    step(1'b1);
    gen_k = 0;
  endtask

  initial begin
    model_reset();
    // reset with toggling input, then a pattern with no run of three zeros
    do_reset();
    step(1); step(0); step(0); step(1); step(0); step(1); step(1);

    // ideal stream through a frame wrap up to k=1000, then a generator restart
    gen_k = 0;
    run(65536 + 1000, 0);
    gen_k = 0;
    run(120, 0);
    restart();
    run(40, 0);

    // mid-operation reset, then a single flip at k=5
    do_reset();
    gen_k = 0;
    flips = '{5};
    run(30, 0);

    // four mismatches in one period drop lock; restarted stream relocks
    do_reset();
    gen_k = 0;
    flips = '{3, 5, 6, 7};
    run(21, 0);
    flips = '{};
    restart();
    run(25, 0);

    // stuck-0 line: one lock, four mismatches, then no relock
    do_reset();
    for (int i = 0; i < 100; i++) step(0);

    // three flips per period keep lock while the narrow counter saturates
    restart();
    run(200, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
